// File: rtl/dict_finder_pkg.sv
// Shared definitions for the dictionary finder: FSM states, link terminator,
// ASCII delimiters, opcode values and the compare fold helper.
// Build option: FORTH_NOCASE_EN makes fold() map 'A'..'Z' to lowercase.
package dict_finder_pkg;

   localparam logic [15:0] NIL = 16'hffff;
   localparam logic [7:0]  SPC = 8'h20;
   localparam logic [7:0]  NUL = 8'h00;

   typedef enum logic [3:0] {
      IDLE, SKIP, TKN, LNK0, LNK1, LEN, CMP, OP, NEXT, DONE
   } fstate_e;

   typedef enum logic [7:0] {
      _NOP  = 8'h01,
      _DUP  = 8'h02,
      _DROP = 8'h03,
      _SWAP = 8'h04,
      _ADD  = 8'h05,
      _SUB  = 8'h06
   } opcode_e;

   // Normalises a byte for name comparison.
   function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef FORTH_NOCASE_EN
      if (b >= 8'h41 && b <= 8'h5a) return b | 8'h20;
`endif
      return b;
   endfunction

endpackage

// File: rtl/mb8_io.sv
// Shared single-port 8-bit memory bus. The master drives a registered
// address and write enable; read data returns one cycle after the address.
interface mb8_io #(parameter int ASZ = 17);
   logic [ASZ-1:0] ai;
   logic           we;
   logic [7:0]     vo;

   modport master (output ai, output we, input vo);
   modport slave  (input ai, input we, output vo);
endinterface

// File: rtl/dict_finder_tkbuf.sv
// Token buffer: TMAX-deep byte register file filled in order by a write
// pointer; bytes past TMAX are dropped. The indexed read port returns the
// byte through fold() (case-insensitive when FORTH_NOCASE_EN is defined).
module dict_tkbuf #(
   parameter int TMAX = 31,
   parameter int AW   = $clog2(TMAX)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          we,
   input  logic [7:0]    wd,
   input  logic [AW-1:0] ra,
   output logic [7:0]    rd
);
   import dict_finder_pkg::*;

   localparam logic [AW:0] TMAX_W = (AW+1)'(TMAX);

   logic [7:0] mem [TMAX];
   logic [AW:0] wptr;

   // Append bytes at the write pointer until the buffer is full.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         for (int i = 0; i < TMAX; i++) mem[i] <= '0;
      end else if (clr) begin
         wptr <= '0;
      end else if (we && wptr < TMAX_W) begin
         mem[wptr[AW-1:0]] <= wd;
         wptr <= wptr + (AW+1)'(1);
      end
   end

   assign rd = fold(mem[ra]);

endmodule

// File: rtl/dict_finder.sv
// Dictionary finder: scans one whitespace-delimited token from the TIB and
// walks the dictionary linked list from ctx looking for a matching name.
// Memory reads are pipelined: an address issued in one cycle returns data on
// vo in the next, so streaming states advance ai every cycle and the byte on
// vo always belongs to a_p1 (the address issued one cycle earlier).
// Build option: FORTH_NOCASE_EN selects case-insensitive name compare.
module dict_finder #(
   parameter int          ASZ  = 17,
   parameter int          TMAX = 31,
   parameter logic [15:0] NIL  = 16'hffff
) (
   input  logic           clk,
   input  logic           rst,
   mb8_io.master          b8_if,
   input  logic           en,
   input  logic [ASZ-1:0] ctx,
   input  logic [ASZ-1:0] tib,
   output logic           bsy,
   output logic           done,
   output logic           hit,
   output logic [7:0]     op,
   output logic [ASZ-1:0] lfa,
   output logic [ASZ-1:0] pfa,
   output logic [ASZ-1:0] nxt,
   output logic [7:0]     tlen
);
   import dict_finder_pkg::*;

   localparam int AW = $clog2(TMAX);

   fstate_e        state;
   logic           pend;
   logic [ASZ-1:0] ai_r;
   logic [ASZ-1:0] a_p1;
   logic [ASZ-1:0] ctx_r;
   logic [ASZ-1:0] cur;
   logic [15:0]    link;
   logic [7:0]     n;
   logic [7:0]     cnt;
   logic [AW-1:0]  idx;
   logic           tb_clr;
   logic           tb_we;
   logic [7:0]     tb_rd;
   logic           is_dlm;

   assign b8_if.ai = ai_r;
   assign b8_if.we = 1'b0;

   assign is_dlm = (b8_if.vo == SPC) || (b8_if.vo == NUL);

   // Buffer control: restart on accepted start, capture every token byte.
   always_comb begin
      tb_clr = (state == IDLE) && en;
      tb_we  = 1'b0;
      if (!pend && !is_dlm && (state == SKIP || state == TKN)) tb_we = 1'b1;
   end

   dict_tkbuf #(.TMAX(TMAX), .AW(AW)) u_tkbuf (
      .clk (clk),
      .rst (rst),
      .clr (tb_clr),
      .we  (tb_we),
      .wd  (b8_if.vo),
      .ra  (idx),
      .rd  (tb_rd)
   );

   // Search FSM: token scan, list walk, name compare and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pend  <= 1'b0;
         ai_r  <= '0;
         a_p1  <= '0;
         ctx_r <= '0;
         cur   <= '0;
         link  <= '0;
         n     <= '0;
         cnt   <= '0;
         idx   <= '0;
         bsy   <= 1'b0;
         done  <= 1'b0;
         hit   <= 1'b0;
         op    <= '0;
         lfa   <= ASZ'(NIL);
         pfa   <= '0;
         nxt   <= '0;
         tlen  <= '0;
      end else begin
         a_p1 <= ai_r;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  ctx_r <= ctx;
                  ai_r  <= tib;
                  pend  <= 1'b1;
                  bsy   <= 1'b1;
                  hit   <= 1'b0;
                  op    <= '0;
                  lfa   <= ASZ'(NIL);
                  pfa   <= '0;
                  state <= SKIP;
               end
            end
            SKIP: begin
               if (pend) begin
                  pend <= 1'b0;
                  ai_r <= ai_r + ASZ'(1);
               end else if (b8_if.vo == SPC) begin
                  ai_r <= ai_r + ASZ'(1);
               end else if (b8_if.vo == NUL) begin
                  nxt   <= a_p1;
                  tlen  <= '0;
                  state <= DONE;
               end else begin
                  cnt   <= 8'd1;
                  ai_r  <= ai_r + ASZ'(1);
                  state <= TKN;
               end
            end
            TKN: begin
               if (is_dlm) begin
                  nxt  <= a_p1;
                  tlen <= cnt;
                  if (cnt > 8'(TMAX)) begin
                     state <= DONE;
                  end else begin
                     cur   <= ctx_r;
                     ai_r  <= ctx_r;
                     pend  <= 1'b1;
                     state <= LNK0;
                  end
               end else begin
                  if (cnt != 8'hff) cnt <= cnt + 8'd1;
                  ai_r <= ai_r + ASZ'(1);
               end
            end
            LNK0: begin
               if (pend) begin
                  pend <= 1'b0;
                  ai_r <= ai_r + ASZ'(1);
               end else begin
                  link[7:0] <= b8_if.vo;
                  ai_r      <= ai_r + ASZ'(1);
                  state     <= LNK1;
               end
            end
            LNK1: begin
               link[15:8] <= b8_if.vo;
               ai_r       <= ai_r + ASZ'(1);
               state      <= LEN;
            end
            LEN: begin
               n     <= b8_if.vo;
               idx   <= '0;
               ai_r  <= ai_r + ASZ'(1);
               state <= (b8_if.vo == tlen) ? CMP : NEXT;
            end
            CMP: begin
               if (fold(b8_if.vo) != tb_rd) begin
                  state <= NEXT;
               end else if (8'(idx) + 8'd1 == n) begin
                  // ai already holds cur+3+n: the opcode arrives next cycle
                  state <= OP;
               end else begin
                  idx  <= idx + AW'(1);
                  ai_r <= ai_r + ASZ'(1);
               end
            end
            OP: begin
               op    <= b8_if.vo;
               pfa   <= a_p1;
               lfa   <= cur;
               hit   <= 1'b1;
               state <= DONE;
            end
            NEXT: begin
               if (link == NIL) begin
                  state <= DONE;
               end else begin
                  cur   <= ASZ'(link);
                  ai_r  <= ASZ'(link);
                  pend  <= 1'b1;
                  state <= LNK0;
               end
            end
            DONE: begin
               done  <= 1'b1;
               bsy   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dict_finder.sv
// Testbench for dict_finder: 128K byte memory behind mb8_io, the setup
// writer's dictionary and TIB, a string-level reference model and a
// scoreboard checked by a monitor on every done pulse.
module tb_dict_finder;
   import dict_finder_pkg::*;

   typedef struct packed {
      logic        hit;
      logic [7:0]  op;
      logic [16:0] lfa;
      logic [16:0] pfa;
      logic [16:0] nxt;
      logic [7:0]  tlen;
   } res_t;

   localparam logic [16:0] CTX = 17'h123;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [16:0] ctx;
   logic [16:0] tib;
   logic        bsy, done, hit;
   logic [7:0]  op, tlen;
   logic [16:0] lfa, pfa, nxt;

   logic [7:0] mem [0:(1<<17)-1];
   res_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   dones  = 0;
   bit   dict_rd, gap_rd, we_bad;

   mb8_io #(.ASZ(17)) b8 ();

   dict_finder dut (
      .clk(clk), .rst(rst), .b8_if(b8), .en(en), .ctx(ctx), .tib(tib),
      .bsy(bsy), .done(done), .hit(hit), .op(op), .lfa(lfa), .pfa(pfa),
      .nxt(nxt), .tlen(tlen)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory model.
   always @(posedge clk) b8.vo <= mem[b8.ai];

   // Bus activity observers.
   always @(posedge clk) begin
      if (bsy && b8.ai >= 17'h100) dict_rd = 1'b1;
      if (bsy && b8.ai >= 17'h100 && b8.ai <= 17'h11d) gap_rd = 1'b1;
   end
   always @(negedge clk) if (b8.we !== 1'b0) we_bad = 1'b1;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst && done) begin
         res_t e;
         dones++;
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("hit", 32'(hit), 32'(e.hit));
            chk("op", 32'(op), 32'(e.op));
            chk("lfa", 32'(lfa), 32'(e.lfa));
            chk("nxt", 32'(nxt), 32'(e.nxt));
            chk("tlen", 32'(tlen), 32'(e.tlen));
            chk("bsy_at_done", 32'(bsy), 32'd0);
            if (e.hit) chk("pfa", 32'(pfa), 32'(e.pfa));
         end
      end
   end

   function automatic logic [7:0] bfold(input logic [7:0] b);
`ifdef FORTH_NOCASE_EN
      if (b >= "A" && b <= "Z") return b + 8'd32;
`endif
      return b;
   endfunction

   // Reference: parse the token as a string, then search the list by name.
   function automatic res_t model(input logic [16:0] t, input logic [16:0] c);
      res_t r;
      logic [16:0] a, st, e;
      logic [15:0] lk;
      int len;
      bit ok;
      r = '0;
      r.lfa = 17'h0ffff;
      a = t;
      while (mem[a] == 8'h20) a = a + 17'd1;
      if (mem[a] == 8'h00) begin
         r.nxt = a;
         return r;
      end
      st = a;
      len = 0;
      while (mem[a] != 8'h20 && mem[a] != 8'h00) begin
         a = a + 17'd1;
         len++;
      end
      r.nxt  = a;
      r.tlen = (len > 255) ? 8'hff : 8'(len);
      if (len > 31) return r;
      e = c;
      for (int g = 0; g < 100; g++) begin
         if (int'(mem[e + 17'd2]) == len) begin
            ok = 1'b1;
            for (int i = 0; i < len; i++)
               if (bfold(mem[e + 17'd3 + 17'(i)]) != bfold(mem[st + 17'(i)])) ok = 1'b0;
            if (ok) begin
               r.hit = 1'b1;
               r.op  = mem[e + 17'd3 + 17'(len)];
               r.lfa = e;
               r.pfa = e + 17'd3 + 17'(len);
               return r;
            end
         end
         lk = {mem[e + 17'd1], mem[e]};
         if (lk == 16'hffff) return r;
         e = {1'b0, lk};
      end
      return r;
   endfunction

   task automatic put_str(input logic [16:0] a, input string s);
      for (int i = 0; i < s.len(); i++) mem[a + 17'(i)] = s[i];
   endtask

   task automatic put_entry(input logic [16:0] a, input logic [15:0] lk,
                            input string nm, input logic [7:0] opc);
      mem[a] = lk[7:0];
      mem[a + 17'd1] = lk[15:8];
      mem[a + 17'd2] = 8'(nm.len());
      put_str(a + 17'd3, nm);
      mem[a + 17'd3 + 17'(nm.len())] = opc;
   endtask

   task automatic run(input logic [16:0] t, input logic [16:0] c);
      int d0, k;
      d0 = dones;
      sbq.push_back(model(t, c));
      @(negedge clk);
      tib = t; ctx = c; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      k = 0;
      while (dones == d0 && k < 1500) begin
         @(posedge clk);
         k++;
      end
      chk("done_count", 32'(dones - d0), 32'd1);
      @(negedge clk);
   endtask

   string words[12] = '{"dup", "DUP", "Dup", "drop", "swap", "SWAP",
                        "+", "-", "nop", "du", "dupx", "x"};

   initial begin
      int d0, k, nlead, wl;
      string s;
      rst = 1'b1; en = 1'b0; ctx = '0; tib = '0;
      dict_rd = 0; gap_rd = 0; we_bad = 0;
      for (int i = 0; i < (1<<17); i++) mem[i] = 8'h00;
      put_str(17'h0, "123 dup + 456 -");
      mem[17'h0f] = 8'h00;
      put_entry(17'h100, 16'hffff, "nop",  _NOP);
      put_entry(17'h107, 16'h0100, "dup",  _DUP);
      put_entry(17'h10e, 16'h0107, "drop", _DROP);
      put_entry(17'h116, 16'h010e, "swap", _SWAP);
      put_entry(17'h11e, 16'h0116, "+",    _ADD);
      put_entry(17'h123, 16'h011e, "-",    _SUB);

      repeat (3) @(negedge clk);
      chk("rst_bsy", 32'(bsy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_hit", 32'(hit), 32'd0);
      chk("rst_op", 32'(op), 32'd0);
      chk("rst_lfa", 32'(lfa), 32'h0ffff);
      chk("rst_pfa", 32'(pfa), 32'd0);
      chk("rst_nxt", 32'(nxt), 32'd0);
      chk("rst_tlen", 32'(tlen), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run(17'd4, CTX);
      gap_rd = 0;
      run(17'd7, CTX);
      chk("plus_walk_skips_gap", 32'(gap_rd), 32'd0);
      run(17'd0, CTX);
      dict_rd = 0;
      run(17'h0f, CTX);
      chk("nul_no_dict_read", 32'(dict_rd), 32'd0);
      run(17'h0d, CTX);

      // Reset while comparing the "dup" entry name.
      d0 = dones;
      @(negedge clk);
      tib = 17'd4; ctx = CTX; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      k = 0;
      while (b8.ai != 17'h10b && k < 1500) begin
         @(posedge clk);
         k++;
      end
      chk("abort_reached_cmp", 32'(k < 1500), 32'd1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort_bsy", 32'(bsy), 32'd0);
      repeat (40) @(negedge clk);
      chk("abort_no_done", 32'(dones - d0), 32'd0);
      run(17'd4, CTX);

      // Start pulse while busy must be ignored.
      d0 = dones;
      sbq.push_back(model(17'd4, CTX));
      @(negedge clk);
      tib = 17'd4; ctx = CTX; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      repeat (5) @(negedge clk);
      tib = 17'd0; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      k = 0;
      while (dones == d0 && k < 1500) begin
         @(posedge clk);
         k++;
      end
      repeat (60) @(negedge clk);
      chk("busy_en_ignored", 32'(dones - d0), 32'd1);

      // Case handling and length limits.
      put_str(17'h300, " DUP");
      run(17'h300, CTX);
      for (int i = 0; i < 32; i++) mem[17'h400 + 17'(i)] = "a";
      mem[17'h420] = 8'h00;
      run(17'h400, CTX);
      mem[17'h41f] = 8'h20;
      run(17'h400, CTX);

      // Randomized tokens and list heads.
      for (int it = 0; it < 24; it++) begin
         nlead = $urandom_range(0, 3);
         for (int i = 0; i < nlead; i++) mem[17'h500 + 17'(i)] = 8'h20;
         if ($urandom_range(0, 3) == 0) begin
            wl = $urandom_range(1, 36);
            s = "";
            for (int i = 0; i < wl; i++) mem[17'h500 + 17'(nlead + i)] = 8'($urandom_range(8'h61, 8'h7a));
         end else begin
            s = words[$urandom_range(0, 11)];
            wl = s.len();
            put_str(17'h500 + 17'(nlead), s);
         end
         mem[17'h500 + 17'(nlead + wl)] = ($urandom_range(0, 1) == 1) ? 8'h20 : 8'h00;
         case ($urandom_range(0, 3))
            0: run(17'h500, 17'h116);
            1: run(17'h500, 17'h107);
            default: run(17'h500, CTX);
         endcase
      end

      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      chk("we_always_low", 32'(we_bad), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
